// File: rtl/ntt_stream_serdes_if.sv
// Stream/core bundle for ntt_stream_serdes: LANES-wide valid/ready streams plus N-wide core vector ports.
interface ntt_stream_serdes_if #(
    parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
    parameter int unsigned INPUT_PER_CYCLE      = 64,
    parameter int unsigned LANES                = 4
);
    localparam int unsigned W = DATA_WIDTH_PER_INPUT;
    localparam int unsigned N = INPUT_PER_CYCLE;

    logic               s_valid;
    logic               s_ready;
    logic [LANES*W-1:0] s_data;
    logic               core_in_valid;
    logic               core_in_ready;
    logic [N*W-1:0]     core_in_data;
    logic               core_out_valid;
    logic [N*W-1:0]     core_out_data;
    logic               out_full;
    logic               overflow;
    logic               m_valid;
    logic               m_ready;
    logic [LANES*W-1:0] m_data;
    logic               m_last;

    // Environment side: feeds beats, acts as the core, consumes output beats.
    modport master (
        output s_valid, s_data, core_in_ready, core_out_valid, core_out_data, m_ready,
        input  s_ready, core_in_valid, core_in_data, out_full, overflow, m_valid, m_data, m_last
    );

    // Adapter side.
    modport slave (
        input  s_valid, s_data, core_in_ready, core_out_valid, core_out_data, m_ready,
        output s_ready, core_in_valid, core_in_data, out_full, overflow, m_valid, m_data, m_last
    );
endinterface

// File: rtl/ntt_stream_serdes.sv
// Lane-parametrised deserialiser / vector FIFO / serialiser around the NTT core.
// Define NTT_STREAM_SERDES_BITREV_EN to emit output vectors in bit-reversed element order.
module ntt_stream_serdes #(
    parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
    parameter int unsigned INPUT_PER_CYCLE      = 64,
    parameter int unsigned LANES                = 4,
    parameter int unsigned OUT_DEPTH            = 2
) (
    input logic               clk,
    input logic               rst,
    ntt_stream_serdes_if.slave bus
);
    localparam int unsigned W     = DATA_WIDTH_PER_INPUT;
    localparam int unsigned N     = INPUT_PER_CYCLE;
    localparam int unsigned BEATS = N / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(OUT_DEPTH + 1);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} in_state_e;

    in_state_e       state_q, state_d;
    logic [BW-1:0]   ibeat_q, ibeat_d;
    logic [N*W-1:0]  asm_q;
    logic            s_ready_c;
    logic            core_in_valid_c;
    logic            in_accept;
    logic            in_last;

    assign in_accept = bus.s_valid && s_ready_c;
    assign in_last   = (ibeat_q == BW'(BEATS - 1));

    // Input FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Input FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_accept && in_last) state_d = HOLD;
            HOLD:    if (bus.core_in_ready)    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Input FSM: outputs; s_ready is held low while reset is asserted
    always_comb begin
        s_ready_c       = 1'b0;
        core_in_valid_c = 1'b0;
        case (state_q)
            FILL:    s_ready_c       = !rst;
            HOLD:    core_in_valid_c = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ibeat_d = ibeat_q;
        if (in_accept) ibeat_d = in_last ? '0 : ibeat_q + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ibeat_q <= '0;
        else     ibeat_q <= ibeat_d;
    end

    // Assembly register only written in FILL, so it is stable throughout HOLD.
    always_ff @(posedge clk) begin
        if (in_accept) asm_q[int'(ibeat_q)*LANES*W +: LANES*W] <= bus.s_data;
    end

    assign bus.s_ready       = s_ready_c;
    assign bus.core_in_valid = core_in_valid_c;
    assign bus.core_in_data  = asm_q;

    // Output vector FIFO
    logic [N*W-1:0] mem_q [OUT_DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [BW-1:0]  obeat_q, obeat_d;
    logic           overflow_q, overflow_d;
    logic           m_valid_c, m_last_c, beat_xfer, pop, push, full_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_c    = (count_q == CW'(OUT_DEPTH));
    assign m_valid_c = (count_q != '0);
    assign m_last_c  = m_valid_c && (obeat_q == BW'(BEATS - 1));
    assign beat_xfer = m_valid_c && bus.m_ready;
    assign pop       = beat_xfer && m_last_c;
    // A final-beat pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign push      = bus.core_out_valid && (!full_c || pop);

    always_comb begin
        wptr_d     = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d     = pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q || (bus.core_out_valid && !push);
        obeat_d    = obeat_q;
        if (beat_xfer) obeat_d = m_last_c ? '0 : obeat_q + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            obeat_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            obeat_q    <= obeat_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.core_out_data;
    end

    logic [N*W-1:0] head;
    assign head = mem_q[rptr_q];

`ifdef NTT_STREAM_SERDES_BITREV_EN
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] x);
        logic [IW-1:0] r;
        for (int i = 0; i < int'(IW); i++) r[i] = x[int'(IW)-1-i];
        return r;
    endfunction

    // Each lane picks its element from the head vector through a bit-reversed index.
    for (genvar j = 0; j < int'(LANES); j++) begin : g_lane
        logic [IW-1:0] src_idx;
        assign src_idx = bitrev(IW'(int'(obeat_q) * int'(LANES) + j));
        assign bus.m_data[j*W +: W] = head[int'(src_idx)*W +: W];
    end
`else
    assign bus.m_data = head[int'(obeat_q)*LANES*W +: LANES*W];
`endif

    assign bus.m_valid  = m_valid_c;
    assign bus.m_last   = m_last_c;
    assign bus.out_full = full_c;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ntt_stream_serdes.sv
// Directed bench for ntt_stream_serdes (N=64, LANES=4, OUT_DEPTH=2) with hand-computed expectations.
module tb_ntt_stream_serdes;
    localparam int unsigned W         = 28;
    localparam int unsigned N         = 64;
    localparam int unsigned LANES     = 4;
    localparam int unsigned OUT_DEPTH = 2;
    localparam int unsigned BEATS     = N / LANES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ntt_stream_serdes_if #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(N), .LANES(LANES)) bus ();

    ntt_stream_serdes #(
        .DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(N), .LANES(LANES), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Element index carried by output beat b, lane j.
    function automatic int exp_idx(input int b, input int j);
        int e;
        int r;
        e = b * int'(LANES) + j;
`ifdef NTT_STREAM_SERDES_BITREV_EN
        r = 0;
        for (int i = 0; i < 6; i++) if (e[i]) r = r | (1 << (5 - i));
`else
        r = e;
`endif
        return r;
    endfunction

    task automatic send_beats(input int base, input int nbeats);
        int g;
        bus.s_valid = 1'b1;
        for (int k = 0; k < nbeats; k++) begin
            for (int j = 0; j < int'(LANES); j++)
                bus.s_data[j*W +: W] = W'(base + k * int'(LANES) + j);
            g = 0;
            while (!bus.s_ready && g < 64) begin
                step();
                g++;
            end
            if (g == 64) check("s_ready_timeout", 32'd0, 32'd1);
            if (k == int'(BEATS) - 1) check("in_valid_before_last", 32'(bus.core_in_valid), 32'd0);
            step();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic check_in_vec(input string tag, input int base);
        for (int i = 0; i < int'(N); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(bus.core_in_data[i*W +: W]), 32'(base + i));
    endtask

    task automatic push_out(input int base);
        bus.core_out_valid = 1'b1;
        for (int i = 0; i < int'(N); i++) bus.core_out_data[i*W +: W] = W'(base + i);
        step();
        bus.core_out_valid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int b, input int base);
        check($sformatf("%s_valid[%0d]", tag, b), 32'(bus.m_valid), 32'd1);
        check($sformatf("%s_last[%0d]", tag, b), 32'(bus.m_last), (b == int'(BEATS) - 1) ? 32'd1 : 32'd0);
        for (int j = 0; j < int'(LANES); j++)
            check($sformatf("%s_data[%0d][%0d]", tag, b, j), 32'(bus.m_data[j*W +: W]),
                  32'(base + exp_idx(b, j)));
    endtask

    task automatic drain_vec(input string tag, input int base);
        for (int b = 0; b < int'(BEATS); b++) begin
            check_beat(tag, b, base);
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.s_valid        = 1'b0;
        bus.s_data         = '0;
        bus.core_in_ready  = 1'b0;
        bus.core_out_valid = 1'b0;
        bus.core_out_data  = '0;
        bus.m_ready        = 1'b0;

        // Reset values
        step();
        step();
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_core_in_valid", 32'(bus.core_in_valid), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_out_full", 32'(bus.out_full), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Assembly with core_in_ready tied high
        bus.core_in_ready = 1'b1;
        send_beats(1, int'(BEATS));
        check("asm_in_valid", 32'(bus.core_in_valid), 32'd1);
        check("asm_s_ready", 32'(bus.s_ready), 32'd0);
        check_in_vec("asm_elem", 1);
        step();
        check("asm_in_valid_drop", 32'(bus.core_in_valid), 32'd0);
        check("asm_s_ready_back", 32'(bus.s_ready), 32'd1);

        // Core backpressure: vector held, input stalled
        bus.core_in_ready = 1'b0;
        send_beats(32'h200, int'(BEATS));
        bus.s_valid = 1'b1;
        for (int j = 0; j < int'(LANES); j++) bus.s_data[j*W +: W] = W'(32'h300 + j);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("hold_s_ready[%0d]", c), 32'(bus.s_ready), 32'd0);
            check($sformatf("hold_in_valid[%0d]", c), 32'(bus.core_in_valid), 32'd1);
            check($sformatf("hold_e0[%0d]", c), 32'(bus.core_in_data[0 +: W]), 32'h200);
            check($sformatf("hold_e37[%0d]", c), 32'(bus.core_in_data[37*W +: W]), 32'h225);
            check($sformatf("hold_e63[%0d]", c), 32'(bus.core_in_data[63*W +: W]), 32'h23F);
            step();
        end
        bus.core_in_ready = 1'b1;
        step();
        bus.core_in_ready = 1'b0;
        check("release_s_ready", 32'(bus.s_ready), 32'd1);
        check("release_in_valid", 32'(bus.core_in_valid), 32'd0);
        send_beats(32'h300, int'(BEATS));
        check("refill_in_valid", 32'(bus.core_in_valid), 32'd1);
        check_in_vec("refill_elem", 32'h300);
        bus.core_in_ready = 1'b1;
        step();
        bus.core_in_ready = 1'b0;

        // Serialise one vector with m_ready high
        bus.m_ready = 1'b1;
        check("ser_idle_m_valid", 32'(bus.m_valid), 32'd0);
        push_out(32'h100);
        drain_vec("ser", 32'h100);
        check("ser_empty", 32'(bus.m_valid), 32'd0);

        // Fill to full, overflow on third vector, drain two
        bus.m_ready = 1'b0;
        push_out(32'h400);
        check("ovf_full_1", 32'(bus.out_full), 32'd0);
        push_out(32'h500);
        check("ovf_full_2", 32'(bus.out_full), 32'd1);
        check("ovf_flag_2", 32'(bus.overflow), 32'd0);
        push_out(32'h600);
        check("ovf_flag_3", 32'(bus.overflow), 32'd1);
        check("ovf_full_3", 32'(bus.out_full), 32'd1);
        bus.m_ready = 1'b1;
        drain_vec("ovf_v1", 32'h400);
        drain_vec("ovf_v2", 32'h500);
        check("ovf_empty", 32'(bus.m_valid), 32'd0);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Write coincident with final-beat pop while full
        bus.m_ready = 1'b0;
        do_reset();
        check("sim_ovf_cleared", 32'(bus.overflow), 32'd0);
        push_out(32'h700);
        push_out(32'h800);
        check("sim_full", 32'(bus.out_full), 32'd1);
        bus.m_ready = 1'b1;
        for (int b = 0; b < int'(BEATS) - 1; b++) begin
            check_beat("sim_a", b, 32'h700);
            step();
        end
        check_beat("sim_a", int'(BEATS) - 1, 32'h700);
        push_out(32'h900);
        check("sim_overflow", 32'(bus.overflow), 32'd0);
        check("sim_still_full", 32'(bus.out_full), 32'd1);
        drain_vec("sim_b", 32'h800);
        drain_vec("sim_c", 32'h900);
        check("sim_empty", 32'(bus.m_valid), 32'd0);

        // Reset mid-frame with a queued vector
        bus.m_ready = 1'b0;
        send_beats(32'hA00, 7);
        push_out(32'hB00);
        check("mid_queued", 32'(bus.m_valid), 32'd1);
        do_reset();
        #1;
        check("mid_m_valid", 32'(bus.m_valid), 32'd0);
        check("mid_in_valid", 32'(bus.core_in_valid), 32'd0);
        check("mid_out_full", 32'(bus.out_full), 32'd0);
        bus.m_ready = 1'b1;
        step();
        check("mid_no_beat", 32'(bus.m_valid), 32'd0);
        send_beats(32'hC00, int'(BEATS));
        check("mid_clean_valid", 32'(bus.core_in_valid), 32'd1);
        check_in_vec("mid_clean", 32'hC00);
        bus.core_in_ready = 1'b1;
        step();
        bus.core_in_ready = 1'b0;

`ifdef NTT_STREAM_SERDES_BITREV_EN
        // Bit-reversed emission, element i = i
        bus.m_ready = 1'b0;
        push_out(0);
        check("brev_l0", 32'(bus.m_data[0 +: W]), 32'd0);
        check("brev_l1", 32'(bus.m_data[W +: W]), 32'd32);
        check("brev_l2", 32'(bus.m_data[2*W +: W]), 32'd16);
        check("brev_l3", 32'(bus.m_data[3*W +: W]), 32'd48);
        bus.m_ready = 1'b1;
        drain_vec("brev", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ntt_stream_serdes.md
Name: ntt_stream_serdes

Overview:
- Width-generalised I/O adapter for the NTT core datapath.
- Deserialises a narrow valid/ready input stream of LANES coefficients per beat into one full INPUT_PER_CYCLE-wide vector for the core.
- Buffers core output vectors in a small vector FIFO and serialises them back to a LANES-wide valid/ready stream with frame marking.
- Replaces the fixed one-word-per-cycle counter wrapper with a backpressure-aware, lane-parametrised block.

Parameters:
- DATA_WIDTH_PER_INPUT, 28, bits per coefficient (W).
- INPUT_PER_CYCLE, 64, coefficients per core vector (N); power of two.
- LANES, 4, coefficients per stream beat; power of two, divides N, 1 <= LANES <= N.
- OUT_DEPTH, 2, output vector FIFO depth in vectors; >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  LANES*W  lane j at bits [j*W +: W]
- core_in_valid  out  1  assembled vector valid
- core_in_ready  in  1  core accepts vector
- core_in_data  out  N*W  element i at bits [i*W +: W]
- core_out_valid  in  1  core output vector strobe; no backpressure
- core_out_data  in  N*W  core output vector, same packing
- out_full  out  1  output FIFO holds OUT_DEPTH vectors
- overflow  out  1  sticky: a core output vector was dropped
- m_valid  out  1  output beat valid
- m_ready  in  1  output beat taken when m_valid && m_ready
- m_data  out  LANES*W  output beat, same lane packing as s_data
- m_last  out  1  final beat of a vector

Behaviour:
- BEATS = N/LANES. Input beat k, lane j carries element k*LANES+j.
- Input FSM, states FILL and HOLD. Reset state is FILL, beat counter 0.
- FILL:
  - s_ready=1, core_in_valid=0.
  - Each accepted beat writes its lanes into the assembly register and increments the counter.
  - Accepting beat BEATS-1 wraps the counter to 0 and moves to HOLD. core_in_valid rises the next cycle (1-cycle latency from last beat).
- HOLD:
  - s_ready=0, core_in_valid=1, core_in_data stable.
  - On core_in_ready, return to FILL. s_ready=1 from the next cycle (no same-cycle pass-through).
- Output FIFO:
  - Holds OUT_DEPTH vectors, with write pointer, read pointer and count.
  - core_out_valid while count<OUT_DEPTH writes the vector.
  - core_out_valid while count==OUT_DEPTH and no pop completes this cycle: vector dropped, overflow set to 1, held until reset.
  - Simultaneous write and final-beat pop while full: both happen, count unchanged, no overflow.
- Serialiser:
  - m_valid=1 whenever count>0.
  - Beat b of the head vector presents elements b*LANES..b*LANES+LANES-1. Beat counter advances on handshake.
  - m_last=1 on beat BEATS-1. Its handshake pops the vector and wraps the beat counter to 0.
  - m_data and m_last are held stable while m_valid && !m_ready.
  - Write-to-m_valid latency is 1 cycle (core_out_valid at t gives m_valid at t+1 when the FIFO was empty).
- out_full = (count==OUT_DEPTH), combinational from registered count.
- Reset values: s_ready=0 during reset, 1 in the first cycle after; core_in_valid=0, m_valid=0, m_last=0, out_full=0, overflow=0. Counters and pointers go to 0. Data registers are don't-care but outputs are masked by their valids.
- Reset mid-frame discards the partial input vector and all buffered output vectors. No beat is emitted in the cycle after reset deassertion.
- LANES==N: BEATS=1 and every beat is a full vector; m_last is constantly 1 when m_valid.

Optional Feature:
- Macro NTT_STREAM_SERDES_BITREV_EN.
- Defined: the serialiser emits the head vector in bit-reversed element order. Output beat b, lane j carries element bitrev_log2(N)(b*LANES+j). Input ordering is unchanged.
- Undefined: natural order as above; no bit-reversal logic is synthesised.

Test Plan:
- N=64, LANES=4: send 16 beats with element i = i+1, core_in_ready tied 1 -> core_in_valid for exactly one cycle, 1 cycle after beat 15; element i == i+1; s_ready low in that cycle.
- core_in_ready held 0 for 10 cycles after assembly -> s_ready=0 and core_in_data stable for all 10 cycles; the first new beat is accepted the cycle after the core_in_ready pulse.
- Inject vector element i = 0x100+i, m_ready=1 -> 16 beats; beat 3 lane 2 = 0x10E; m_last only on beat 15.
- OUT_DEPTH=2, m_ready=0, three core_out_valid pulses -> out_full=1 after the second pulse; third pulse sets overflow=1; draining yields exactly 32 beats of vectors 1 and 2.
- Full FIFO, core_out_valid coincident with the final-beat m_last handshake -> overflow stays 0, count stays 2.
- rst asserted after 7 accepted input beats and with 1 vector queued -> m_valid=0 and core_in_valid=0 afterwards; the next 16 beats form a clean vector.
- With BITREV_EN, element i = i -> beat 0 lanes = {0,32,16,48}.
